// File: rtl/debug_run_controller.sv
// Run/step/halt sequencer for the MIPS debug unit: gates the pipeline step enable,
// detects end/breakpoint/host/count stops and hands off to the dump serializer.
module debug_run_controller #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_arg,
  input  logic             i_bp_enable,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             is_stop_pipe,
  input  logic             i_dump_done,
  output logic             o_cmd_ready,
  output logic             o_step,
  output logic             o_dump_req,
  output logic             o_busy,
  output logic [2:0]       o_halt_cause,
  output logic [CYC_W-1:0] o_cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_RUNN, S_DUMP, S_ENDED} state_t;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_RUNN = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_END   = 3'd1;
  localparam logic [2:0] C_BP    = 3'd2;
  localparam logic [2:0] C_HOST  = 3'd3;
  localparam logic [2:0] C_STEP  = 3'd4;
  localparam logic [2:0] C_COUNT = 3'd5;

  state_t           state, state_d;
  logic [CNT_W-1:0] n_cnt;
  logic             skip;
  logic             accept, bp_hit, halt_cmd, cnt_done, stop, running;
  logic [2:0]       stop_cause;

  assign accept   = i_cmd_valid && o_cmd_ready;
  assign running  = (state == S_RUN) || (state == S_RUNN);
  assign bp_hit   = i_bp_enable && (i_pc == i_bp_addr) && !skip;
  assign halt_cmd = accept && (i_cmd_op == OP_HALT);
  // Counter holds the steps still owed, so the last one is issued while it reads 1.
  assign cnt_done = (state == S_RUNN) && (n_cnt == CNT_W'(1));

  always_comb begin
    stop       = 1'b1;
    stop_cause = C_NONE;
    if (is_stop_pipe)  stop_cause = C_END;
    else if (bp_hit)   stop_cause = C_BP;
    else if (halt_cmd) stop_cause = C_HOST;
    else if (cnt_done) stop_cause = C_COUNT;
    else               stop       = 1'b0;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (i_cmd_op)
            OP_RUN:  state_d = S_RUN;
            OP_STEP: state_d = S_STEP;
            OP_RUNN: state_d = (i_cmd_arg == '0) ? S_DUMP : S_RUNN;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN, S_RUNN: if (stop) state_d = S_DUMP;
      S_STEP:        state_d = S_DUMP;
      S_DUMP: begin
        if (i_dump_done) state_d = (o_halt_cause == C_END) ? S_ENDED : S_IDLE;
      end
      S_ENDED:       state_d = S_ENDED;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      n_cnt         <= '0;
      skip          <= 1'b0;
      o_cmd_ready   <= 1'b1;
      o_step        <= 1'b0;
      o_dump_req    <= 1'b0;
      o_busy        <= 1'b0;
      o_halt_cause  <= C_NONE;
      o_cycle_count <= '0;
    end else begin
      state       <= state_d;
      o_cmd_ready <= (state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_RUNN);
      o_busy      <= (state_d != S_IDLE);
      o_dump_req  <= (state_d == S_DUMP);
      o_step      <= (state_d == S_RUN) || (state_d == S_RUNN) ||
                     (state == S_IDLE && state_d == S_STEP);

      if (o_step) begin
        o_cycle_count <= o_cycle_count + CYC_W'(1);
        skip          <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            o_halt_cause <= C_NONE;
            if (i_cmd_op == OP_RUN) skip <= 1'b1;
            if (i_cmd_op == OP_RUNN) begin
              if (i_cmd_arg == '0) begin
                o_halt_cause <= C_COUNT;
              end else begin
                n_cnt <= i_cmd_arg;
                skip  <= 1'b1;
              end
            end
          end
        end
        S_RUN, S_RUNN: begin
          if (state == S_RUNN && o_step) n_cnt <= n_cnt - CNT_W'(1);
          if (running && stop) o_halt_cause <= stop_cause;
        end
        S_STEP: o_halt_cause <= is_stop_pipe ? C_END : C_STEP;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed bench for debug_run_controller: expected halts are queued when a command
// is issued and checked against the DUT when it raises its dump request.
module tb_debug_run_controller;

  localparam int PC_W = 8, CNT_W = 16, CYC_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_cmd_valid;
  logic [1:0]       i_cmd_op;
  logic [CNT_W-1:0] i_cmd_arg;
  logic             i_bp_enable;
  logic [PC_W-1:0]  i_bp_addr;
  logic [PC_W-1:0]  i_pc;
  logic             is_stop_pipe;
  logic             i_dump_done;
  logic             o_cmd_ready, o_step, o_dump_req, o_busy;
  logic [2:0]       o_halt_cause;
  logic [CYC_W-1:0] o_cycle_count;

  debug_run_controller #(.PC_W(PC_W), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op),
    .i_cmd_arg(i_cmd_arg), .i_bp_enable(i_bp_enable), .i_bp_addr(i_bp_addr),
    .i_pc(i_pc), .is_stop_pipe(is_stop_pipe), .i_dump_done(i_dump_done),
    .o_cmd_ready(o_cmd_ready), .o_step(o_step), .o_dump_req(o_dump_req),
    .o_busy(o_busy), .o_halt_cause(o_halt_cause), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] cyc;
    int          steps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   steps = 0;
  bit   pc_auto = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: count steps seen before the edge, and let the PC model follow them.
  task automatic tick();
    bit stepped;
    stepped = (o_step === 1'b1);
    if (stepped) steps++;
    @(posedge clk);
    #1;
    if (pc_auto && stepped) i_pc = i_pc + 8'd4;
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_arg   = arg;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] cause, input logic [31:0] cyc, input int n);
    exp_t e;
    e.cause = cause;
    e.cyc   = cyc;
    e.steps = n;
    sb.push_back(e);
  endtask

  task automatic wait_dump(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (o_dump_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_dump_seen"}, {31'd0, o_dump_req}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cause"}, {29'd0, o_halt_cause}, {29'd0, e.cause});
      chk({tag, "_cycles"}, o_cycle_count, e.cyc);
      chk({tag, "_steps"}, steps, e.steps);
      chk({tag, "_step_low"}, {31'd0, o_step}, 32'd0);
    end
  endtask

  task automatic dump_done();
    i_dump_done = 1'b1;
    tick();
    i_dump_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = 2'd0; i_cmd_arg = '0;
    i_bp_enable = 1'b0; i_bp_addr = '0; i_pc = '0; is_stop_pipe = 1'b0; i_dump_done = 1'b0;
    #12;
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rst_step", {31'd0, o_step}, 32'd0);
    chk("rst_dump", {31'd0, o_dump_req}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_cause", {29'd0, o_halt_cause}, 32'd0);
    chk("rst_count", o_cycle_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: single step
    steps = 0;
    push(3'd4, 32'd1, 1);
    send(2'd1, '0);
    chk("step_high", {31'd0, o_step}, 32'd1);
    chk("step_ready", {31'd0, o_cmd_ready}, 32'd0);
    wait_dump("step");
    dump_done();
    chk("step_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("step_idle_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("step_cause_hold", {29'd0, o_halt_cause}, 32'd4);
    dump_done();  // stray done in IDLE must be ignored
    chk("stray_done_busy", {31'd0, o_busy}, 32'd0);

    // 2: RUN_N 5 then RUN_N 0
    steps = 0;
    push(3'd5, 32'd6, 5);
    send(2'd2, 16'd5);
    chk("runn_cause_clr", {29'd0, o_halt_cause}, 32'd0);
    wait_dump("runn5");
    dump_done();
    steps = 0;
    push(3'd5, 32'd6, 0);
    send(2'd2, 16'd0);
    wait_dump("runn0");
    dump_done();

    // 3: breakpoint stop, then resume from the breakpoint PC
    i_bp_enable = 1'b1; i_bp_addr = 8'h0C; i_pc = 8'h00; pc_auto = 1'b1;
    steps = 0;
    push(3'd2, 32'd10, 4);
    send(2'd0, '0);
    wait_dump("bp");
    dump_done();
    i_pc = 8'h0C;
    steps = 0;
    send(2'd0, '0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_skip_step", {31'd0, o_step}, 32'd1);
    chk("bp_skip_nodump", {31'd0, o_dump_req}, 32'd0);
    push(3'd3, 32'd14, 4);
    send(2'd3, '0);
    wait_dump("host");
    dump_done();
    pc_auto = 1'b0;

    // 6: dump held off for 100 cycles while the host keeps sending RUN
    steps = 0;
    push(3'd5, 32'd14, 0);
    send(2'd2, 16'd0);
    wait_dump("hold");
    i_cmd_valid = 1'b1; i_cmd_op = 2'd0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("hold_dump", {31'd0, o_dump_req}, 32'd1);
      chk("hold_step", {31'd0, o_step}, 32'd0);
      chk("hold_ready", {31'd0, o_cmd_ready}, 32'd0);
    end
    i_cmd_valid = 1'b0;
    dump_done();
    chk("hold_idle", {31'd0, o_busy}, 32'd0);
    chk("hold_count", o_cycle_count, 32'd14);

    // 4: HALT, END and breakpoint coincide -> END wins, then ENDED
    i_bp_enable = 1'b1; i_bp_addr = 8'h0C; i_pc = 8'h20;
    steps = 0;
    send(2'd0, '0);
    for (int i = 0; i < 9; i++) tick();
    push(3'd1, 32'd24, 10);
    is_stop_pipe = 1'b1; i_pc = 8'h0C;
    send(2'd3, '0);
    is_stop_pipe = 1'b0;
    wait_dump("end");
    dump_done();
    chk("ended_busy", {31'd0, o_busy}, 32'd1);
    chk("ended_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("ended_dump", {31'd0, o_dump_req}, 32'd0);
    send(2'd0, '0);
    tick();
    chk("ended_nostep", {31'd0, o_step}, 32'd0);
    chk("ended_stay", {31'd0, o_busy}, 32'd1);
    chk("ended_cause", {29'd0, o_halt_cause}, 32'd1);

    // 5: async reset in the middle of a run
    i_bp_enable = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    send(2'd0, '0);
    tick(); tick();
    chk("prerst_step", {31'd0, o_step}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_step", {31'd0, o_step}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_count", o_cycle_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("post_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("post_busy", {31'd0, o_busy}, 32'd0);
    chk("post_count", o_cycle_count, 32'd0);
    chk("post_cause", {29'd0, o_halt_cause}, 32'd0);
    steps = 0;
    push(3'd4, 32'd1, 1);
    send(2'd1, '0);
    wait_dump("post_step");
    dump_done();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
